// File: rtl/ghr_pkg.sv
// Shared types and the history shift used by the global-history checkpoint controller.
package ghr_pkg;

    localparam int G_WIDTH = 9;
    localparam int DEPTH   = 8;
    localparam int TAG_W   = $clog2(DEPTH);

    typedef logic [G_WIDTH:0] history_t;
    typedef logic [TAG_W-1:0] ckpt_tag_t;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } ctrl_state_t;

    function automatic history_t shift_hist(input history_t h, input logic b);
        return {h[G_WIDTH-1:0], b};
    endfunction

endpackage

// File: rtl/ghr_ckpt_ram.sv
// Checkpoint register file: one synchronous write port, one asynchronous read port.
module ghr_ckpt_ram
    import ghr_pkg::*;
#(
    parameter int NUM = 8,
    parameter int AW  = $clog2(NUM)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  history_t      wdata,
    input  logic [AW-1:0] raddr,
    output history_t      rdata
);

    history_t mem [NUM];

    // Contents carry no reset; every entry is written before it can be read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ghr_checkpoint_ctrl.sv
// Speculative/architectural global history with per-branch checkpoints for
// misprediction and flush repair.
module ghr_checkpoint_ctrl
    import ghr_pkg::*;
#(
    parameter int DEPTH = ghr_pkg::DEPTH,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             predValid,
    input  logic             predTaken,
    output logic             ckptReady,
    output logic [TAG_W-1:0] ckptTag,
    input  logic             resolveValid,
    input  logic [TAG_W-1:0] resolveTag,
    input  logic             mispredict,
    input  logic             actualTaken,
    input  logic             commitValid,
    input  logic             commitTaken,
    input  logic             flush,
    output history_t         specHistory,
    output history_t         archHistory,
    output logic [TAG_W:0]   count,
    output logic             full,
    output logic             empty
);

    logic [TAG_W:0] head, tail, head_nxt, tail_nxt, rel_tag;
    history_t       spec_q, arch_q, spec_nxt, arch_nxt, ckpt_rd;
    ctrl_state_t    state, state_nxt;
    logic           misp_req, misp_ev, commit_ev, alloc_ev;

    assign count     = tail - head;
    assign full      = (count == (TAG_W+1)'(DEPTH));
    assign empty     = (count == '0);
    assign ckptReady = (state == RUN) && !full;
    assign ckptTag   = tail[TAG_W-1:0];

    assign misp_req  = resolveValid && mispredict;
    assign misp_ev   = misp_req && !flush;
    assign commit_ev = commitValid && !empty;
    assign alloc_ev  = predValid && ckptReady && !misp_req && !flush;

    // Distance from the oldest live entry to the resolving branch, modulo DEPTH.
    assign rel_tag   = {1'b0, resolveTag - head[TAG_W-1:0]};

    ghr_ckpt_ram #(
        .NUM (DEPTH),
        .AW  (TAG_W)
    ) u_ram (
        .clk   (clk),
        .we    (alloc_ev),
        .waddr (tail[TAG_W-1:0]),
        .wdata (spec_q),
        .raddr (resolveTag),
        .rdata (ckpt_rd)
    );

    always_comb begin
        head_nxt  = head + (TAG_W+1)'(commit_ev);
        arch_nxt  = commit_ev ? shift_hist(arch_q, commitTaken) : arch_q;
        tail_nxt  = tail;
        spec_nxt  = spec_q;
        state_nxt = RUN;
        if (flush) begin
            spec_nxt = arch_nxt;
            tail_nxt = head_nxt;
        end else if (misp_ev) begin
            spec_nxt = shift_hist(ckpt_rd, actualTaken);
            tail_nxt = head + rel_tag + (TAG_W+1)'(1);
        end else if (alloc_ev) begin
            spec_nxt = shift_hist(spec_q, predTaken);
            tail_nxt = tail + (TAG_W+1)'(1);
        end
        if ((state == RUN) && (flush || misp_ev)) begin
            state_nxt = RECOVER;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head   <= '0;
            tail   <= '0;
            spec_q <= '0;
            arch_q <= '0;
            state  <= RUN;
        end else begin
            head   <= head_nxt;
            tail   <= tail_nxt;
            spec_q <= spec_nxt;
            arch_q <= arch_nxt;
            state  <= state_nxt;
        end
    end

    assign specHistory = spec_q;
    assign archHistory = arch_q;

endmodule

// File: tb/tb_ghr_checkpoint_ctrl.sv
// Bench for ghr_checkpoint_ctrl: queue-based history model, directed scenarios, random traffic.
module tb_ghr_checkpoint_ctrl;

    localparam int DEPTH = 4;
    localparam int TAG_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             predValid = 1'b0, predTaken = 1'b0;
    logic             ckptReady;
    logic [TAG_W-1:0] ckptTag;
    logic             resolveValid = 1'b0;
    logic [TAG_W-1:0] resolveTag = '0;
    logic             mispredict = 1'b0, actualTaken = 1'b0;
    logic             commitValid = 1'b0, commitTaken = 1'b0;
    logic             flush = 1'b0;
    logic [9:0]       specHistory, archHistory;
    logic [TAG_W:0]   count;
    logic             full, empty;

    int checks = 0;
    int errors = 0;

    // Model: live checkpoints oldest-first, tag of the oldest, both histories, recovery flag.
    logic [9:0] m_q[$];
    logic [9:0] m_spec, m_arch;
    int         m_head;
    bit         m_rec;

    ghr_checkpoint_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .predValid(predValid), .predTaken(predTaken),
        .ckptReady(ckptReady), .ckptTag(ckptTag),
        .resolveValid(resolveValid), .resolveTag(resolveTag),
        .mispredict(mispredict), .actualTaken(actualTaken),
        .commitValid(commitValid), .commitTaken(commitTaken),
        .flush(flush),
        .specHistory(specHistory), .archHistory(archHistory),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [9:0] sh(input logic [9:0] h, input bit b);
        return 10'(((int'(h) * 2) + int'(b)) % 1024);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_spec = '0;
        m_arch = '0;
        m_head = 0;
        m_rec  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        predValid = 1'b1;
        predTaken = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk("async_reset_spec", int'(specHistory), 0);
        @(negedge clk);
        predValid = 1'b0;
        predTaken = 1'b0;
        rst_n     = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic step(input bit pv, input bit pt, input bit rv, input int rt,
                        input bit mp, input bit at, input bit cv, input bit ct, input bit fl);
        bit         exp_ready, commit;
        int         k;
        logic [9:0] arch_n;
        @(negedge clk);
        predValid    = pv;
        predTaken    = pt;
        resolveValid = rv;
        resolveTag   = TAG_W'(rt);
        mispredict   = mp;
        actualTaken  = at;
        commitValid  = cv;
        commitTaken  = ct;
        flush        = fl;
        #1;
        exp_ready = !m_rec && (m_q.size() < DEPTH);
        chk("specHistory", int'(specHistory), int'(m_spec));
        chk("archHistory", int'(archHistory), int'(m_arch));
        chk("count", int'(count), m_q.size());
        chk("full", int'(full), int'(m_q.size() == DEPTH));
        chk("empty", int'(empty), int'(m_q.size() == 0));
        chk("ckptReady", int'(ckptReady), int'(exp_ready));
        if (pv && exp_ready) chk("ckptTag", int'(ckptTag), (m_head + m_q.size()) % DEPTH);

        commit = cv && (m_q.size() > 0);
        arch_n = commit ? sh(m_arch, ct) : m_arch;
        if (fl) begin
            m_q.delete();
            if (commit) m_head = (m_head + 1) % DEPTH;
            m_spec = arch_n;
            m_rec  = 1'b1;
        end else begin
            if (rv && mp) begin
                k = (rt - m_head + DEPTH) % DEPTH;
                checks++;
                assert (k < m_q.size()) else begin
                    errors++;
                    $display("FAIL live_tag: got tag %0d expected live (%0d entries)", rt, m_q.size());
                end
                if (k < m_q.size()) begin
                    m_spec = sh(m_q[k], at);
                    while (m_q.size() > k + 1) void'(m_q.pop_back());
                end
                m_rec = 1'b1;
            end else begin
                if (pv && exp_ready) begin
                    m_q.push_back(m_spec);
                    m_spec = sh(m_spec, pt);
                end
                m_rec = 1'b0;
            end
            if (commit) begin
                void'(m_q.pop_front());
                m_head = (m_head + 1) % DEPTH;
            end
        end
        m_arch = arch_n;
    endtask

    initial begin
        bit pv, pt, rv, mp, at, cv, ct, fl;
        int rt;
        model_reset();
        #12;
        rst_n = 1'b1;

        // Reset in the middle of an allocate
        do_reset();
        chk("rst_spec", int'(specHistory), 'h000);
        chk("rst_arch", int'(archHistory), 'h000);
        chk("rst_empty", int'(empty), 1);
        chk("rst_ready", int'(ckptReady), 1);
        chk("rst_count", int'(count), 0);

        // Allocate T, T, N
        step(1, 1, 0, 0, 0, 0, 0, 0, 0); chk("tag_a0", int'(ckptTag), 0);
        after_edge();                   chk("spec_a0", int'(specHistory), 'h001);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0); chk("tag_a1", int'(ckptTag), 1);
        after_edge();                   chk("spec_a1", int'(specHistory), 'h003);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0); chk("tag_a2", int'(ckptTag), 2);
        after_edge();
        chk("spec_a2", int'(specHistory), 'h006);
        chk("count_a2", int'(count), 3);
        chk("ckpt2", int'(dut.u_ram.mem[2]), 'h003);

        // Mispredict on tag 1, then commit tag 0 during the recovery cycle
        step(0, 0, 1, 1, 1, 0, 0, 0, 0);
        after_edge();
        chk("misp_spec", int'(specHistory), 'h002);
        chk("misp_count", int'(count), 2);
        chk("misp_ready", int'(ckptReady), 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0);
        after_edge();
        chk("commit_arch", int'(archHistory), 'h001);
        chk("recover_done", int'(ckptReady), 1);

        // Fill to full, reject a fifth, commit, wrap tag
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        after_edge();
        chk("full_flag", int'(full), 1);
        chk("full_ready", int'(ckptReady), 0);
        chk("full_spec", int'(specHistory), 'h00F);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0);
        after_edge();
        chk("ignored_spec", int'(specHistory), 'h00F);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0);
        after_edge();
        chk("unfull_flag", int'(full), 0);
        chk("unfull_ready", int'(ckptReady), 1);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0); chk("wrap_tag", int'(ckptTag), 0);
        after_edge();                   chk("wrap_spec", int'(specHistory), 'h01F);

        // Reach count=3, arch=0x005, then flush with a same-cycle commit
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1, 0);
        after_edge();
        chk("pre_flush_arch", int'(archHistory), 'h005);
        chk("pre_flush_count", int'(count), 3);
        step(0, 0, 0, 0, 0, 0, 1, 1, 1);
        after_edge();
        chk("flush_spec", int'(specHistory), 'h00B);
        chk("flush_arch", int'(archHistory), 'h00B);
        chk("flush_empty", int'(empty), 1);
        chk("flush_ready", int'(ckptReady), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Allocation dropped in favour of a mispredict on tag 0
        step(1, 1, 0, 0, 0, 0, 0, 0, 0); chk("tag_post_flush", int'(ckptTag), 0);
        step(1, 1, 1, 0, 1, 0, 0, 0, 0);
        after_edge();
        chk("drop_spec", int'(specHistory), 'h016);
        chk("drop_count", int'(count), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            pv = ($urandom_range(0, 3) != 0);
            pt = $urandom_range(0, 1);
            rv = !m_rec && (m_q.size() > 0) && ($urandom_range(0, 3) == 0);
            rt = rv ? (m_head + int'($urandom_range(0, m_q.size() - 1))) % DEPTH : 0;
            mp = $urandom_range(0, 1);
            at = $urandom_range(0, 1);
            cv = ($urandom_range(0, 2) == 0);
            ct = $urandom_range(0, 1);
            fl = !m_rec && ($urandom_range(0, 24) == 0);
            if (cv && rv && mp && !fl && (rt == m_head)) cv = 1'b0;
            step(pv, pt, rv, rt, mp, at, cv, ct, fl);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
